// File: rtl/demod_sched_pkg.sv
// Shared types and constants for the demodulation pipeline scheduler.
//   state_e      : scheduler FSM states
//   NUM_SEG      : number of result segments returned by the pipeline
//   SEG_W        : width of one segment and of one requester data word
//   DEF_*        : default values for the scheduler parameters
package demod_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   localparam int NUM_SEG      = 10;
   localparam int SEG_W        = 32;

   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_PIPE_LAT = 3;
   localparam int DEF_TIMEOUT  = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector, one bit per requester
//   ptr_i : index where the priority search begins
//   gnt_o : one-hot grant (all zero when no request is pending)
//   idx_o : index of the granted requester (zero when nothing is granted)
module rr_arbiter
   import demod_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic             found;
   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Walk the requesters starting at ptr_i, wrapping around; the first one
   // found wins, which keeps the grant one-hot by construction.
   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand     = (int'(ptr_i) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/demod_pipe_scheduler.sv
// Shares one demodulation pipeline among NUM_REQ requesters.
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   req            : per-requester request levels
//   req_data       : per-requester 32-bit words, slice i for requester i
//   ack            : one-cycle one-hot grant pulse
//   pipe_input_bit : word handed to the pipeline, stable until next grant
//   pipe_start     : pipeline start level, high while a job runs
//   pipe_valid     : pipeline result valid
//   pipe_segment   : ten 32-bit result segments from the pipeline
//   res_valid      : one-cycle strobe when a result is captured
//   res_id         : requester that owns the captured result
//   res_seg        : captured segments, held until the next capture
//   sched_busy     : high whenever the FSM is not idle
//   timeout_err    : sticky flag set when a job exceeds TIMEOUT cycles
module demod_pipe_scheduler
   import demod_sched_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*SEG_W-1:0]      req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [SEG_W-1:0]              pipe_input_bit,
   output logic                          pipe_start,
   input  logic                          pipe_valid,
   input  logic [NUM_SEG*SEG_W-1:0]      pipe_segment,
   output logic                          res_valid,
   output logic [$clog2(NUM_REQ)-1:0]    res_id,
   output logic [NUM_SEG*SEG_W-1:0]      res_seg,
   output logic                          sched_busy,
   output logic                          timeout_err
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   // A pipeline that cannot finish before the abort limit would never
   // deliver a result, so reject that configuration at elaboration.
   if (TIMEOUT <= PIPE_LAT) begin : g_bad_cfg
      $error("demod_pipe_scheduler: TIMEOUT must exceed PIPE_LAT");
   end

   state_e                     state_q, state_d;
   logic [IDX_W-1:0]           ptr_q, ptr_d;
   logic [IDX_W-1:0]           winner_q, winner_d;
   logic [WAIT_W-1:0]          wait_q, wait_d;
   logic [NUM_REQ-1:0]         ack_q, ack_d;
   logic [SEG_W-1:0]           pin_q, pin_d;
   logic                       start_q, start_d;
   logic                       rvld_q, rvld_d;
   logic [IDX_W-1:0]           rid_q, rid_d;
   logic [NUM_SEG*SEG_W-1:0]   rseg_q, rseg_d;
   logic                       terr_q, terr_d;

   logic [NUM_REQ-1:0]         arb_gnt;
   logic [IDX_W-1:0]           arb_idx;
   logic [SEG_W-1:0]           sel_word;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx)
   );

   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            sel_word = req_data[i*SEG_W +: SEG_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      winner_d = winner_q;
      wait_d   = wait_q;
      ack_d    = '0;
      pin_d    = pin_q;
      start_d  = start_q;
      rvld_d   = 1'b0;
      rid_d    = rid_q;
      rseg_d   = rseg_q;
      terr_d   = terr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req) begin
               ack_d    = arb_gnt;
               pin_d    = sel_word;
               start_d  = 1'b1;
               winner_d = arb_idx;
               wait_d   = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // A valid arriving on the last allowed cycle still counts as a
            // result, so it is checked before the timeout.
            if (pipe_valid) begin
               rseg_d  = pipe_segment;
               rid_d   = winner_q;
               rvld_d  = 1'b1;
               start_d = 1'b0;
               state_d = ST_RELEASE;
            end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               start_d = 1'b0;
               state_d = ST_RELEASE;
            end else begin
               wait_d  = wait_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (winner_q == IDX_W'(NUM_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = winner_q + 1'b1;
            end
            wait_d  = '0;
            state_d = ST_IDLE;
         end
         default: begin
            start_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         winner_q <= '0;
         wait_q   <= '0;
         ack_q    <= '0;
         pin_q    <= '0;
         start_q  <= 1'b0;
         rvld_q   <= 1'b0;
         rid_q    <= '0;
         rseg_q   <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         winner_q <= winner_d;
         wait_q   <= wait_d;
         ack_q    <= ack_d;
         pin_q    <= pin_d;
         start_q  <= start_d;
         rvld_q   <= rvld_d;
         rid_q    <= rid_d;
         rseg_q   <= rseg_d;
         terr_q   <= terr_d;
      end
   end

   assign ack            = ack_q;
   assign pipe_input_bit = pin_q;
   assign pipe_start     = start_q;
   assign res_valid      = rvld_q;
   assign res_id         = rid_q;
   assign res_seg        = rseg_q;
   assign sched_busy     = (state_q != ST_IDLE);
   assign timeout_err    = terr_q;

endmodule

// File: tb/tb_demod_pipe_scheduler.sv
// Directed bench for demod_pipe_scheduler with a simple pipeline model.
module tb_demod_pipe_scheduler;

   localparam int NR = 4;
   localparam int PL = 3;
   localparam int TO = 15;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'hA5A5_0003;
   localparam logic [31:0] D3 = 32'h4444_0003;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req;
   logic [NR*32-1:0] req_data;
   logic [NR-1:0]    ack;
   logic [31:0]      pib;
   logic             ps;
   logic             pv;
   logic [319:0]     pseg;
   logic             rv;
   logic [1:0]       rid;
   logic [319:0]     rseg;
   logic             busy;
   logic             terr;

   int total = 0;
   int bad   = 0;

   logic       model_en = 1'b1;
   logic       force_v  = 1'b0;
   logic [7:0] salt     = 8'h00;
   int         cnt      = 0;

   always #5 clk = ~clk;

   demod_pipe_scheduler #(
      .NUM_REQ  (NR),
      .PIPE_LAT (PL),
      .TIMEOUT  (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .req_data       (req_data),
      .ack            (ack),
      .pipe_input_bit (pib),
      .pipe_start     (ps),
      .pipe_valid     (pv),
      .pipe_segment   (pseg),
      .res_valid      (rv),
      .res_id         (rid),
      .res_seg        (rseg),
      .sched_busy     (busy),
      .timeout_err    (terr)
   );

   // Pipeline model: valid one cycle after start has been seen PL times.
   always @(posedge clk) begin
      if (!ps) cnt <= 0;
      else     cnt <= cnt + 1;
   end
   assign pv = force_v | (model_en && cnt == PL);

   function automatic logic [319:0] segs(input logic [31:0] w, input logic [7:0] s);
      logic [319:0] r;
      r = '0;
      for (int k = 0; k < 10; k++) begin
         r[32*k +: 32] = w ^ (32'h0101_0101 * 32'(k + 1)) ^ {24'h0, s};
      end
      return r;
   endfunction

   assign pseg = segs(pib, salt);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (busy && n < lim) begin
         tick();
         n++;
      end
      chk("idle_bound", busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int gcnt;
      int gcyc[8];
      int gidx[8];

      reset    = 1'b0;
      req      = '0;
      req_data = {D3, D2, D1, D0};

      // Reset state
      tick();
      tick();
      chk("rst_ack", ack, 4'b0);
      chk("rst_start", ps, 1'b0);
      chk("rst_pib", pib, 32'h0);
      chk("rst_rv", rv, 1'b0);
      chk("rst_rseg", rseg, 320'h0);
      chk("rst_terr", terr, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;

      // Single requester 2
      req = 4'b0100;
      tick();
      chk("s_ack", ack, 4'b0100);
      chk("s_pib", pib, D2);
      chk("s_start", ps, 1'b1);
      chk("s_busy", busy, 1'b1);
      req = 4'b0000;
      tick();
      chk("s_ack_pulse", ack, 4'b0);
      tick();
      tick();
      chk("s_rv_early", rv, 1'b0);
      tick();
      chk("s_rv", rv, 1'b1);
      chk("s_rid", rid, 2'd2);
      chk("s_rseg", rseg, segs(D2, 8'h00));
      chk("s_rel_start", ps, 1'b0);
      chk("s_rel_busy", busy, 1'b1);
      tick();
      chk("s_rv_pulse", rv, 1'b0);
      chk("s_idle", busy, 1'b0);

      // All requesters active after a fresh reset
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req   = 4'b1111;
      gcnt  = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         chk("rr_onehot", ($countones(ack) <= 1), 1'b1);
         if (ack != 4'b0 && gcnt < 8) begin
            for (int b = 0; b < NR; b++) if (ack[b]) gidx[gcnt] = b;
            gcyc[gcnt] = c;
            gcnt++;
         end
      end
      req = 4'b0000;
      chk("rr_count", gcnt, 7);
      chk("rr_first_cycle", gcyc[0], 1);
      for (int n = 0; n < 6; n++) begin
         chk("rr_order", gidx[n], n % NR);
         if (n > 0) chk("rr_spacing", gcyc[n] - gcyc[n-1], PL + 3);
      end
      wait_idle(20);

      // Timeout: pipeline never answers
      model_en = 1'b0;
      req      = 4'b0010;
      tick();
      chk("to_ack", ack, 4'b0010);
      chk("to_pib", pib, D1);
      req = 4'b0000;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         chk("to_rv_run", rv, 1'b0);
         chk("to_terr_run", terr, 1'b0);
      end
      tick();
      chk("to_terr", terr, 1'b1);
      chk("to_rv", rv, 1'b0);
      chk("to_rel_busy", busy, 1'b1);
      chk("to_start", ps, 1'b0);
      chk("to_rseg_kept", rseg, segs(D2, 8'h00));
      chk("to_rid_kept", rid, 2'd2);
      tick();
      chk("to_idle", busy, 1'b0);
      model_en = 1'b1;
      req      = 4'b0001;
      tick();
      chk("to_next_ack", ack, 4'b0001);
      req = 4'b0000;
      tick();
      tick();
      tick();
      tick();
      chk("to_next_rv", rv, 1'b1);
      chk("to_next_rid", rid, 2'd0);
      chk("to_next_rseg", rseg, segs(D0, 8'h00));
      chk("to_sticky", terr, 1'b1);
      wait_idle(5);

      // Reset asserted two cycles into RUN
      req = 4'b1000;
      tick();
      chk("rr_ack3", ack, 4'b1000);
      req = 4'b0000;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("ar_ack", ack, 4'b0);
      chk("ar_pib", pib, 32'h0);
      chk("ar_start", ps, 1'b0);
      chk("ar_rv", rv, 1'b0);
      chk("ar_rid", rid, 2'd0);
      chk("ar_rseg", rseg, 320'h0);
      chk("ar_terr", terr, 1'b0);
      chk("ar_busy", busy, 1'b0);
      tick();
      chk("ar_rv_hold", rv, 1'b0);
      reset = 1'b1;
      req   = 4'b1000;
      tick();
      chk("ar_ack3", ack, 4'b1000);
      chk("ar_pib3", pib, D3);
      req = 4'b0000;
      tick();
      tick();
      tick();
      tick();
      chk("ar_rv3", rv, 1'b1);
      chk("ar_rid3", rid, 2'd3);
      chk("ar_rseg3", rseg, segs(D3, 8'h00));
      wait_idle(5);

      // pipe_valid outside RUN
      salt    = 8'h5A;
      force_v = 1'b1;
      tick();
      tick();
      chk("pv_idle_rv", rv, 1'b0);
      chk("pv_idle_busy", busy, 1'b0);
      chk("pv_idle_rseg", rseg, segs(D3, 8'h00));
      force_v = 1'b0;
      salt    = 8'h00;
      req     = 4'b0010;
      tick();
      chk("pv_ack", ack, 4'b0010);
      req = 4'b0000;
      tick();
      tick();
      tick();
      tick();
      chk("pv_rv", rv, 1'b1);
      chk("pv_rseg", rseg, segs(D1, 8'h00));
      salt    = 8'h5A;
      force_v = 1'b1;
      tick();
      chk("pv_rel_rv", rv, 1'b0);
      chk("pv_rel_rseg", rseg, segs(D1, 8'h00));
      chk("pv_rel_idle", busy, 1'b0);
      tick();
      chk("pv_idle2_rv", rv, 1'b0);
      force_v = 1'b0;
      salt    = 8'h00;

      // req changes during RUN/RELEASE are ignored
      req = 4'b0010;
      tick();
      chk("ig_ack1", ack, 4'b0010);
      req = 4'b0011;
      tick();
      chk("ig_ack_run", ack, 4'b0);
      req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ig_ack_hold", ack, 4'b0);
      end
      tick();
      chk("ig_ack0", ack, 4'b0001);
      req = 4'b0000;
      wait_idle(10);

      // Valid and timeout in the same cycle
      model_en = 1'b0;
      req      = 4'b0100;
      tick();
      chk("vt_ack", ack, 4'b0100);
      req = 4'b0000;
      for (int i = 0; i < TO - 1; i++) tick();
      force_v = 1'b1;
      tick();
      force_v = 1'b0;
      chk("vt_rv", rv, 1'b1);
      chk("vt_terr", terr, 1'b0);
      chk("vt_rseg", rseg, segs(D2, 8'h00));
      model_en = 1'b1;
      wait_idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
